// File: rtl/reset_sequencer.sv
// reset_sequencer: top-level reset manager. Synchronises the clock-generator
// lock flags, times the external PHY reset pulse, then releases the reset
// stages one after another. Any lock loss or software request re-runs the
// sequence.
module reset_sequencer #(
    parameter int N_LOCKS          = 3,
    parameter int N_STAGES         = 3,
    parameter int SYNC_STAGES      = 2,
    parameter int STABLE_CYCLES    = 1024,
    parameter int STAGE_DELAY      = 256,
    parameter int PHY_RESET_CYCLES = 2048,
    parameter int PHY_ON_LOSS      = 0
) (
    input  logic                i_clock,
    input  logic                i_reset_n,
    input  logic [N_LOCKS-1:0]  i_locked,
    input  logic                i_soft_reset,
    output logic [N_STAGES-1:0] o_stage_reset,
    output logic                o_phy_reset_n,
    output logic                o_ready,
    output logic [7:0]          o_loss_count,
    output logic [2:0]          o_state
);

    typedef enum logic [2:0] {
        PHY_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        RELEASE   = 3'd2,
        RUN       = 3'd3
    } state_t;

    localparam int PHY_W    = $clog2(PHY_RESET_CYCLES + 1);
    localparam int STABLE_W = $clog2(STABLE_CYCLES + 1);
    localparam int DELAY_W  = $clog2(STAGE_DELAY + 1);

    localparam logic [PHY_W-1:0]    PHY_LAST    = PHY_W'(PHY_RESET_CYCLES - 1);
    localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(STABLE_CYCLES - 1);
    localparam logic [DELAY_W-1:0]  DELAY_LAST  = DELAY_W'(STAGE_DELAY - 1);

    localparam logic [N_STAGES-1:0] ALL_ASSERTED = '1;

    logic [1:0]          rstSync_q;
    logic [N_LOCKS-1:0]  lockSync_q [SYNC_STAGES];
    logic                rstDone;
    logic                locksOk;

    state_t              state_q;
    logic [PHY_W-1:0]    phyCnt_q;
    logic [STABLE_W-1:0] stableCnt_q;
    logic [DELAY_W-1:0]  delayCnt_q;
    logic [N_STAGES-1:0] stageReset_q;
    logic                phyResetN_q;
    logic                ready_q;
    logic [7:0]          lossCount_q;

    assign rstDone = rstSync_q[1];
    assign locksOk = &lockSync_q[SYNC_STAGES-1];

    // Two-flop release synchroniser so the FSM leaves PHY_RST cleanly after the async reset lifts
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rstSync_q <= 2'b00;
        end else begin
            rstSync_q <= {rstSync_q[0], 1'b1};
        end
    end

    // Synchronise each lock flag through a SYNC_STAGES-deep flop chain
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                lockSync_q[k] <= '0;
            end
        end else begin
            lockSync_q[0] <= i_locked;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                lockSync_q[k] <= lockSync_q[k-1];
            end
        end
    end

    // Sequencing FSM; every output is a register so stage resets never see an input combinationally
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= PHY_RST;
            phyCnt_q     <= '0;
            stableCnt_q  <= '0;
            delayCnt_q   <= '0;
            stageReset_q <= ALL_ASSERTED;
            phyResetN_q  <= 1'b0;
            ready_q      <= 1'b0;
            lossCount_q  <= 8'd0;
        end else if (i_soft_reset) begin
            state_q      <= PHY_RST;
            phyCnt_q     <= '0;
            stableCnt_q  <= '0;
            delayCnt_q   <= '0;
            stageReset_q <= ALL_ASSERTED;
            phyResetN_q  <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            case (state_q)
                PHY_RST: begin
                    stageReset_q <= ALL_ASSERTED;
                    ready_q      <= 1'b0;
                    if (rstDone) begin
                        if (phyCnt_q == PHY_LAST) begin
                            state_q     <= WAIT_LOCK;
                            phyCnt_q    <= '0;
                            stableCnt_q <= '0;
                            phyResetN_q <= 1'b1;
                        end else begin
                            phyCnt_q <= phyCnt_q + PHY_W'(1);
                        end
                    end
                end
                WAIT_LOCK: begin
                    if (locksOk) begin
                        if (stableCnt_q == STABLE_LAST) begin
                            state_q      <= RELEASE;
                            stableCnt_q  <= '0;
                            delayCnt_q   <= '0;
                            stageReset_q <= ALL_ASSERTED << 1;
                        end else begin
                            stableCnt_q <= stableCnt_q + STABLE_W'(1);
                        end
                    end else begin
                        stableCnt_q <= '0;
                    end
                end
                RELEASE, RUN: begin
                    if (!locksOk) begin
                        stageReset_q <= ALL_ASSERTED;
                        ready_q      <= 1'b0;
                        stableCnt_q  <= '0;
                        delayCnt_q   <= '0;
                        if (lossCount_q != 8'hFF) begin
                            lossCount_q <= lossCount_q + 8'd1;
                        end
                        if (PHY_ON_LOSS != 0) begin
                            state_q     <= PHY_RST;
                            phyCnt_q    <= '0;
                            phyResetN_q <= 1'b0;
                        end else begin
                            state_q <= WAIT_LOCK;
                        end
                    end else if (state_q == RELEASE) begin
                        if (stageReset_q == '0) begin
                            state_q <= RUN;
                            ready_q <= 1'b1;
                        end else if (delayCnt_q == DELAY_LAST) begin
                            delayCnt_q   <= '0;
                            stageReset_q <= stageReset_q << 1;
                        end else begin
                            delayCnt_q <= delayCnt_q + DELAY_W'(1);
                        end
                    end
                end
                default: begin
                    state_q      <= PHY_RST;
                    phyCnt_q     <= '0;
                    stageReset_q <= ALL_ASSERTED;
                    phyResetN_q  <= 1'b0;
                    ready_q      <= 1'b0;
                end
            endcase
        end
    end

    assign o_stage_reset = stageReset_q;
    assign o_phy_reset_n = phyResetN_q;
    assign o_ready       = ready_q;
    assign o_loss_count  = lossCount_q;
    assign o_state       = state_q;

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
Parametrised reset manager that replaces ad-hoc "reset OR not-locked" gating at the FPGA top level.
- Synchronises N asynchronous clock-generator lock flags and qualifies them for stability.
- Generates a minimum-width PHY reset pulse.
- Releases N ordered reset stages with programmable spacing.
- Re-asserts all stages on lock loss or software request, and counts lock-loss events.

Parameters:
N_LOCKS, 3, number of lock inputs (1..8)
N_STAGES, 3, number of sequenced reset outputs (1..8)
SYNC_STAGES, 2, synchroniser flops per lock input (>=2)
STABLE_CYCLES, 1024, consecutive all-locked cycles required before release (>=1)
STAGE_DELAY, 256, cycles between successive stage releases (>=1)
PHY_RESET_CYCLES, 2048, o_phy_reset_n low width in cycles (>=1)
PHY_ON_LOSS, 0, 1 = lock loss also re-runs the PHY reset pulse

Ports:
i_clock  in  1  free-running board clock; all logic on rising edge
i_reset_n  in  1  asynchronous active-low reset
i_locked  in  N_LOCKS  lock flags, asynchronous to i_clock
i_soft_reset  in  1  synchronous single-cycle request for a full re-sequence
o_stage_reset  out  N_STAGES  active-high resets; bit 0 released first
o_phy_reset_n  out  1  active-low external PHY reset
o_ready  out  1  high when all stages are released (state RUN)
o_loss_count  out  8  saturating count of lock-loss events
o_state  out  3  encoded FSM state: 0 PHY_RST, 1 WAIT_LOCK, 2 RELEASE, 3 RUN

Behaviour:
- Reset values, applied asynchronously while i_reset_n=0:
  - o_stage_reset all 1s, o_phy_reset_n 0, o_ready 0, o_loss_count 0, o_state PHY_RST.
  - Synchroniser flops 0; all counters 0.
  - Reset deassertion is synchronised internally with 2 flops before the FSM leaves PHY_RST.
- Synchroniser and lock qualification:
  - Each i_locked bit passes through SYNC_STAGES flops.
  - locks_ok = AND of the synchronised bits.
  - Lock-in to locks_ok latency is SYNC_STAGES cycles.
- PHY_RST:
  - o_phy_reset_n=0; all stages asserted.
  - Counter runs 0..PHY_RESET_CYCLES-1, then go to WAIT_LOCK.
  - o_phy_reset_n goes 1 on the first WAIT_LOCK cycle, so the low width is exactly PHY_RESET_CYCLES after the internal reset release.
- WAIT_LOCK:
  - Stable counter increments each cycle locks_ok=1 and clears to 0 on any cycle locks_ok=0.
  - When the count reaches STABLE_CYCLES, go to RELEASE.
- RELEASE:
  - o_stage_reset[0] deasserts on the first RELEASE cycle.
  - o_stage_reset[k] deasserts exactly STAGE_DELAY cycles after bit k-1.
  - Released bits stay released.
  - After bit N_STAGES-1 deasserts, go to RUN on the next cycle; o_ready=1 from the first RUN cycle.
- RUN: holds until a lock-loss or soft-reset event.
- Lock loss (locks_ok=0 while in RELEASE or RUN):
  - On the next edge, all o_stage_reset bits go to 1 and o_ready goes to 0.
  - o_loss_count increments, saturating at 255 with no wrap.
  - Next state is WAIT_LOCK, or PHY_RST if PHY_ON_LOSS=1.
  - Loss during PHY_RST or WAIT_LOCK is not counted.
- i_soft_reset=1 in any state:
  - Next state is PHY_RST with counters cleared and all stages asserted.
  - o_loss_count is unchanged.
  - Soft reset has priority over a simultaneous lock loss; that loss is not counted.
- Glitch on i_locked shorter than one i_clock period: either ignored or treated as a loss; never produces a partial stage release.
- Stage outputs are registered with no combinational path from any input.

Test Plan (params N_LOCKS=2, N_STAGES=3, SYNC_STAGES=2, STABLE_CYCLES=8, STAGE_DELAY=4, PHY_RESET_CYCLES=5, PHY_ON_LOSS=0):
- Power-up with locks high from the start → o_phy_reset_n low for 5 cycles; stage0 released 8 cycles after WAIT_LOCK entry plus sync latency; stage1 4 cycles later; stage2 4 cycles after that; o_ready=1 the following cycle; o_loss_count=0.
- Lock bit 1 drops for 3 cycles at stable count 5 in WAIT_LOCK → counter restarts; release occurs 8 full locked cycles after relock; o_loss_count stays 0.
- Lock bit 0 drops in RUN → within SYNC_STAGES+1 cycles o_stage_reset=3'b111, o_ready=0, o_loss_count=1, o_phy_reset_n stays 1; on relock, full release sequence repeats.
- i_soft_reset in the same cycle as a synchronised lock loss in RUN → o_state=PHY_RST, o_phy_reset_n low 5 cycles, o_loss_count unchanged.
- 300 forced lock losses in RUN → o_loss_count=255, no wrap.
- i_reset_n asserted mid-RELEASE (stage0 released) → all outputs return to reset values immediately, without waiting for a clock edge.
